// File: rtl/vu_zerodet_pipe.sv
// Multi-lane zero / all-ones / sign-redundant / nonzero detector with per-lane sticky flags.
// Latency: 2 cycles (stage A group reduce, stage B lane reduce + flags); 1 result/cycle.
// Backpressure: stall freezes both stages and their valid bits; acc_clr is still honoured.
module vu_zerodet_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic [1:0]             mode,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [LANES*WIDTH-1:0] data,
  input  logic                   acc_clr,
  output logic                   out_valid,
  output logic [LANES-1:0]       hit,
  output logic                   all_hit,
  output logic                   any_hit,
  output logic [LANES-1:0]       sticky
);

  localparam int GROUPS = WIDTH / 4;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_SIGN = 2'b10;
  localparam logic [1:0] MODE_NZ   = 2'b11;

  // Stage A: per-nibble zero/ones flags plus the transaction's mode and mask.
  logic [LANES*GROUPS-1:0] gz_d, gz_q;
  logic [LANES*GROUPS-1:0] go_d, go_q;
  logic [1:0]              mode_a_d, mode_a_q;
  logic [LANES-1:0]        mask_a_d, mask_a_q;
  logic                    va_d, va_q;

  // Stage B: result registers and sticky accumulator.
  logic                    out_valid_d, out_valid_q;
  logic [LANES-1:0]        hit_d, hit_q;
  logic                    all_hit_d, all_hit_q;
  logic                    any_hit_d, any_hit_q;
  logic [LANES-1:0]        sticky_d, sticky_q;

  logic [LANES-1:0]        hit_new;
  logic                    load_b;

  // Stage A next state: nibble-level reduction, captured only when not stalled.
  always_comb begin
    gz_d     = gz_q;
    go_d     = go_q;
    mode_a_d = mode_a_q;
    mask_a_d = mask_a_q;
    va_d     = va_q;
    if (!stall) begin
      va_d     = in_valid;
      mode_a_d = mode;
      mask_a_d = lane_mask;
      for (int i = 0; i < LANES; i++) begin
        for (int g = 0; g < GROUPS; g++) begin
          gz_d[i*GROUPS+g] = ~|data[i*WIDTH+g*4 +: 4];
          go_d[i*GROUPS+g] = &data[i*WIDTH+g*4 +: 4];
        end
      end
    end
  end

  // Stage B combinational: lane-level reduction and mode select, masked lanes forced to 0.
  always_comb begin
    logic z;
    logic o;
    logic r;
    z       = 1'b0;
    o       = 1'b0;
    r       = 1'b0;
    hit_new = '0;
    for (int i = 0; i < LANES; i++) begin
      z = &gz_q[i*GROUPS +: GROUPS];
      o = &go_q[i*GROUPS +: GROUPS];
      case (mode_a_q)
        MODE_ZERO: r = z;
        MODE_ONES: r = o;
        MODE_SIGN: r = z | o;
        MODE_NZ:   r = ~z;
        default:   r = 1'b0;
      endcase
      hit_new[i] = r & mask_a_q[i];
    end
  end

  assign load_b = va_q & ~stall;

  // Stage B next state: results load only on a valid unstalled cycle; bubbles only drop out_valid.
  always_comb begin
    out_valid_d = out_valid_q;
    hit_d       = hit_q;
    all_hit_d   = all_hit_q;
    any_hit_d   = any_hit_q;
    sticky_d    = sticky_q;
    if (!stall) begin
      out_valid_d = va_q;
    end
    if (load_b) begin
      hit_d     = hit_new;
      all_hit_d = (|mask_a_q) & (&(hit_new | ~mask_a_q));
      any_hit_d = |hit_new;
      sticky_d  = (acc_clr ? '0 : sticky_q) | hit_new;
    end else if (acc_clr) begin
      sticky_d = '0;
    end
  end

  // State registers; reset drops anything in flight and clears the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      gz_q        <= '0;
      go_q        <= '0;
      mode_a_q    <= '0;
      mask_a_q    <= '0;
      va_q        <= 1'b0;
      out_valid_q <= 1'b0;
      hit_q       <= '0;
      all_hit_q   <= 1'b0;
      any_hit_q   <= 1'b0;
      sticky_q    <= '0;
    end else begin
      gz_q        <= gz_d;
      go_q        <= go_d;
      mode_a_q    <= mode_a_d;
      mask_a_q    <= mask_a_d;
      va_q        <= va_d;
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      all_hit_q   <= all_hit_d;
      any_hit_q   <= any_hit_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign all_hit   = all_hit_q;
  assign any_hit   = any_hit_q;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_vu_zerodet_pipe.sv
// Bench for vu_zerodet_pipe: scoreboard of expected lane results, plus a small
// second instance at WIDTH=32/LANES=4 for detect and reset-flush behaviour.
module tb_vu_zerodet_pipe;

  localparam int W = 16;
  localparam int L = 8;
  localparam int W2 = 32;
  localparam int L2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             stall = 1'b0;
  logic             acc_clr = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [L-1:0]     lane_mask = '0;
  logic [L*W-1:0]   data = '0;
  logic             out_valid;
  logic [L-1:0]     hit;
  logic             all_hit;
  logic             any_hit;
  logic [L-1:0]     sticky;

  vu_zerodet_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .mode(mode),
    .lane_mask(lane_mask), .data(data), .acc_clr(acc_clr), .out_valid(out_valid),
    .hit(hit), .all_hit(all_hit), .any_hit(any_hit), .sticky(sticky)
  );

  logic             r2 = 1'b1;
  logic             iv2 = 1'b0;
  logic             st2 = 1'b0;
  logic             ac2 = 1'b0;
  logic [1:0]       md2 = 2'b00;
  logic [L2-1:0]    mk2 = '0;
  logic [L2*W2-1:0] d2 = '0;
  logic             ov2;
  logic [L2-1:0]    hit2;
  logic             all2;
  logic             any2;
  logic [L2-1:0]    stk2;

  vu_zerodet_pipe #(.WIDTH(W2), .LANES(L2)) dut2 (
    .clk(clk), .reset(r2), .in_valid(iv2), .stall(st2), .mode(md2),
    .lane_mask(mk2), .data(d2), .acc_clr(ac2), .out_valid(ov2),
    .hit(hit2), .all_hit(all2), .any_hit(any2), .sticky(stk2)
  );

  typedef struct packed {
    logic [L-1:0] hit;
    logic         all_hit;
    logic         any_hit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Reference: whole-lane compares, independent of the nibble structure.
  function automatic exp_t model(input logic [1:0] md, input logic [L-1:0] mk, input logic [L*W-1:0] dt);
    exp_t e;
    logic [W-1:0] ln;
    logic r;
    e = '0;
    for (int i = 0; i < L; i++) begin
      ln = dt[i*W +: W];
      case (md)
        2'd0:    r = (ln == '0);
        2'd1:    r = (ln == {W{1'b1}});
        2'd2:    r = (ln == '0) || (ln == {W{1'b1}});
        default: r = (ln != '0);
      endcase
      e.hit[i] = r & mk[i];
    end
    e.any_hit = (e.hit != '0);
    e.all_hit = (mk != '0) && (e.hit == mk);
    return e;
  endfunction

  function automatic logic [L*W-1:0] fill(input logic [W-1:0] v);
    logic [L*W-1:0] d;
    for (int i = 0; i < L; i++) d[i*W +: W] = v;
    return d;
  endfunction

  // One clock of stimulus; an accepted transaction is pushed to the scoreboard.
  task automatic step(input logic iv, input logic st, input logic ac, input logic [1:0] md,
                      input logic [L-1:0] mk, input logic [L*W-1:0] dt, input logic rst);
    in_valid  = iv;
    stall     = st;
    acc_clr   = ac;
    mode      = md;
    lane_mask = mk;
    data      = dt;
    reset     = rst;
    @(posedge clk);
    if (iv && !st && !rst) exp_q.push_back(model(md, mk, dt));
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  // Control inputs as seen by the edge just taken.
  logic stall_s = 1'b0;
  logic acc_s = 1'b0;
  logic reset_s = 1'b1;
  always @(posedge clk) begin
    stall_s <= stall;
    acc_s   <= acc_clr;
    reset_s <= reset;
  end

  logic [L-1:0] sticky_m = '0;
  logic [L-1:0] last_hit = '0;
  logic         last_all = 1'b0;
  logic         last_any = 1'b0;
  logic         last_ov = 1'b0;
  exp_t         e;

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (reset_s) begin
      exp_q.delete();
      sticky_m = '0;
      last_hit = '0;
      last_all = 1'b0;
      last_any = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_hit", hit, 0);
      check("rst_all_hit", all_hit, 0);
      check("rst_any_hit", any_hit, 0);
      check("rst_sticky", sticky, 0);
    end else if (!stall_s && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("hit", hit, e.hit);
        check("all_hit", all_hit, e.all_hit);
        check("any_hit", any_hit, e.any_hit);
        sticky_m = (acc_s ? '0 : sticky_m) | e.hit;
        last_hit = e.hit;
        last_all = e.all_hit;
        last_any = e.any_hit;
      end
      check("sticky", sticky, sticky_m);
    end else begin
      if (stall_s) check("stall_out_valid_hold", out_valid, last_ov);
      if (acc_s) sticky_m = '0;
      check("hold_hit", hit, last_hit);
      check("hold_all_hit", all_hit, last_all);
      check("hold_any_hit", any_hit, last_any);
      check("hold_sticky", sticky, sticky_m);
    end
    last_ov = out_valid;
  end

  initial begin
    logic [L*W-1:0] d;
    logic [L*W-1:0] da;
    logic [L*W-1:0] db;
    logic [L*W-1:0] dc;

    step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
    idle(1);

    // Single transaction: lane0 zero, others 1.
    d = fill(16'h0001);
    d[0 +: W] = '0;
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, d, 1'b0);
    idle(2);
    check("t1_sticky", sticky, 8'h01);

    // Mixed lanes in sign-redundant, ones and nonzero modes.
    d = fill(16'hFFFF);
    d[1*W +: W] = 16'h0000;
    d[2*W +: W] = 16'h8000;
    d[3*W +: W] = 16'h7FFF;
    step(1'b1, 1'b0, 1'b0, 2'b10, 8'hFF, d, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b01, 8'hFF, d, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b11, 8'hFF, d, 1'b0);
    idle(2);

    // Back-to-back with a partial mask after clearing the accumulator.
    step(1'b0, 1'b0, 1'b1, 2'b00, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h0F, fill(16'h0000), 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h0F, fill(16'h1234), 1'b0);
    idle(2);
    check("t3_sticky", sticky, 8'h0F);

    // Stall for three cycles with the third input held, acc_clr pulsed mid-stall.
    da = fill(16'h0000);
    db = fill(16'h0001);
    db[0 +: W] = '0;
    dc = fill(16'h0001);
    dc[1*W +: W] = '0;
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, da, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, db, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'hFF, dc, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b00, 8'hFF, dc, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 8'hFF, dc, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, dc, 1'b0);
    idle(3);
    check("stall_sticky", sticky, 8'h03);

    // Empty mask with all-zero data.
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, fill(16'h0000), 1'b0);
    idle(2);
    check("mask0_sticky", sticky, 8'h03);

    // Build sticky = 0xAA, then reset with results in flight.
    d = fill(16'h0001);
    for (int i = 1; i < L; i += 2) d[i*W +: W] = '0;
    step(1'b0, 1'b0, 1'b1, 2'b00, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, d, 1'b0);
    idle(2);
    check("sticky_aa", sticky, 8'hAA);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, d, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, d, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b00, '0, '0, 1'b1);
    check("post_rst_sticky", sticky, 0);
    check("post_rst_out_valid", out_valid, 0);
    idle(4);

    // Second configuration: 32-bit lanes, 4 lanes.
    r2  = 1'b0;
    iv2 = 1'b1;
    md2 = 2'b00;
    mk2 = 4'hF;
    d2  = {32'hFFFF_FFFF, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
    @(posedge clk); #1;
    md2 = 2'b01;
    @(posedge clk); #1;
    check("w32_out_valid", ov2, 1);
    check("w32_hit", hit2, 4'h5);
    check("w32_all_hit", all2, 0);
    check("w32_any_hit", any2, 1);
    check("w32_sticky", stk2, 4'h5);
    iv2 = 1'b0;
    r2  = 1'b1;
    @(posedge clk); #1;
    check("w32_rst_out_valid", ov2, 0);
    check("w32_rst_hit", hit2, 0);
    check("w32_rst_sticky", stk2, 0);
    r2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("w32_no_dropped_result", ov2, 0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vu_zerodet_pipe.md
# vu_zerodet_pipe

Parametrised, pipelined multi-lane zero/ones detector for the vector unit datapath. It generalises the single 16-bit combinational zero detect to LANES independent WIDTH-bit lanes, with selectable detect mode, a lane mask, a two-stage registered pipeline with stall, and per-lane sticky flags for accumulating results across a burst. It sits after the VU result mux and feeds flag/condition logic.

## Interface
- WIDTH, 16, lane width in bits; multiple of 4, range 4..64
- LANES, 8, number of lanes
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  data/mode/mask qualify this cycle
- stall  in  1  freeze both pipeline stages
- mode  in  2  00 zero, 01 all-ones, 10 sign-redundant (all bits equal), 11 nonzero
- lane_mask  in  LANES  1 = lane participates
- data  in  LANES*WIDTH  lane i = data[i*WIDTH +: WIDTH]
- acc_clr  in  1  clear sticky flags
- out_valid  out  1  result registers hold a new result
- hit  out  LANES  per-lane detect result (masked lanes read 0)
- all_hit  out  1  every masked-in lane hit; 0 if mask is all zero
- any_hit  out  1  at least one masked-in lane hit
- sticky  out  LANES  per-lane OR of hit over results since last clear

## Operation
- Stage A (registered): per lane, per 4-bit group g (WIDTH/4 groups): gz = NOR of 4 bits, go = AND of 4 bits. Mode, lane_mask and in_valid registered alongside as vA.
- Stage B (registered): per lane, Z = AND of gz, O = AND of go. Lane result r: mode 00 -> Z; 01 -> O; 10 -> Z|O; 11 -> !Z. hit[i] = r & mask[i]. all_hit = (mask != 0) & &(hit | ~mask). any_hit = |hit. out_valid = vA.
- Stage B loads only when vA = 1 and stall = 0; when vA = 0 and stall = 0, out_valid drops to 0 and hit/all_hit/any_hit hold their previous values.
- Sticky: on the edge stage B loads a valid result, sticky <= (acc_clr ? 0 : sticky) | hit_new. acc_clr with no load: sticky <= 0. acc_clr honoured during stall.
- Stall = 1: stage A and stage B registers (including valid bits) hold; in_valid is ignored that cycle (upstream must hold data).
- Masked lanes never set hit or sticky.

## Timing
- Reset: out_valid, hit, all_hit, any_hit, sticky, all stage-A state = 0. Reset overrides stall and acc_clr; in-flight results are dropped.
- Latency 2 cycles: input sampled at edge N appears on outputs after edge N+1 with out_valid = 1, sticky updated on the same edge.
- Throughput 1 result/cycle with stall = 0; back-to-back valids produce back-to-back out_valid.
- Stall for k cycles delays all in-flight results by exactly k cycles; none lost or duplicated.
- Mode and mask take effect per transaction (travel with data), never retroactively.
- Critical path per stage: one 4-input gate level plus WIDTH/4-input reduction.

## Test plan
- Defaults, mode 00, mask 0xFF, lane0 = 0x0000, others 0x0001, in_valid one cycle -> two cycles later out_valid = 1, hit = 0x01, any_hit = 1, all_hit = 0, sticky = 0x01.
- Mode 10, lanes = {0xFFFF, 0x0000, 0x8000, 0x7FFF, 0xFFFF...}, mask 0xFF -> hit = 0xF3; mode 01 on same data -> hit = 0xF1; mode 11 -> hit = 0xFD.
- Back-to-back: cycle 0 all lanes zero mode 00, cycle 1 all lanes 0x1234 mode 00, mask 0x0F -> results on consecutive cycles hit = 0x0F all_hit = 1, then hit = 0x00 any_hit = 0; sticky = 0x0F after both.
- Stall: issue 3 valid inputs, assert stall 2 cycles after first, hold 3 cycles -> outputs appear in order, each exactly once, out_valid continuous after stall release; acc_clr pulsed mid-stall -> sticky = 0 then reaccumulates only post-stall results.
- Mask 0x00 with all-zero data -> hit = 0, all_hit = 0, any_hit = 0, sticky unchanged.
- Reset asserted with two results in flight and sticky = 0xAA -> next cycle all outputs 0; no out_valid emerges from dropped results. Repeat with WIDTH = 32, LANES = 4.
